// File: rtl/sub_shift_pkg.sv
// Shared nibble-AES definitions: S-box tables, stage FSM encodings and nibble index width.
// Used by the SubNibbles/ShiftRows stage and by key expansion.
package sub_shift_pkg;

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SUB   = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
    4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
    4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
  };

endpackage

// File: rtl/sub_shift_nibble_sbox.sv
// Combinational 4-bit S-box with forward/inverse select.
// Shared between the round datapath and key expansion.
module nibble_sbox
  import sub_shift_pkg::*;
(
  input  logic [3:0] din,
  input  logic       inv,
  output logic [3:0] dout
);

  assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];

endmodule

// File: rtl/sub_shift.sv
// SubNibbles + ShiftRows stage: four nibbles substituted serially through one S-box,
// then the second-row nibbles are swapped and presented on c with a one-cycle dn pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for ld; clears dn; c holds last result
// ST_SUB   | substituting working nibble idx, one per clock
// ST_SHIFT | writing row-swapped working register to c, dn=1
module sub_shift
  import sub_shift_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        ld,
  input  logic        inv,
  input  logic [15:0] s,
  output logic [15:0] c,
  output logic        dn,
  output logic        busy
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [15:0]      work;
  logic             inv_lat;
  logic [3:0]       nib_in;
  logic [3:0]       nib_out;

  // idx 0 is the most significant nibble
  always_comb begin
    nib_in = work[15:12];
    case (idx)
      2'd0: nib_in = work[15:12];
      2'd1: nib_in = work[11:8];
      2'd2: nib_in = work[7:4];
      2'd3: nib_in = work[3:0];
      default: nib_in = work[15:12];
    endcase
  end

  nibble_sbox u_sbox (
    .din  (nib_in),
    .inv  (inv_lat),
    .dout (nib_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ld) state_nxt = ST_SUB;
      ST_SUB:   if (idx == '1) state_nxt = ST_SHIFT;
      ST_SHIFT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work    <= '0;
      inv_lat <= 1'b0;
      idx     <= '0;
      c       <= '0;
      dn      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          dn <= 1'b0;
          if (ld) begin
            work    <= s;
            inv_lat <= inv;
            idx     <= '0;
          end
        end
        ST_SUB: begin
          case (idx)
            2'd0: work[15:12] <= nib_out;
            2'd1: work[11:8]  <= nib_out;
            2'd2: work[7:4]   <= nib_out;
            2'd3: work[3:0]   <= nib_out;
            default: ;
          endcase
          idx <= idx + IDX_W'(1);
        end
        ST_SHIFT: begin
          // swap is self-inverse, so substitute-then-swap serves both directions
          c  <= {work[15:12], work[3:0], work[7:4], work[11:8]};
          dn <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_shift.sv
// Randomized scoreboard bench for sub_shift: driver pushes expected results,
// a negedge monitor pops and compares on every dn pulse.
module tb_sub_shift;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        ld = 1'b0;
  logic        inv = 1'b0;
  logic [15:0] s = 16'h0000;
  logic [15:0] c;
  logic        dn;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  localparam logic [3:0] FWD [16] = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                      4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  localparam logic [3:0] INV [16] = '{4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
                                      4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE};

  sub_shift dut (
    .clk   (clk),
    .n_rst (n_rst),
    .ld    (ld),
    .inv   (inv),
    .s     (s),
    .c     (c),
    .dn    (dn),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference: substitute every nibble, then exchange nibbles 1 and 3.
  function automatic logic [15:0] model(logic [15:0] x, logic iv);
    logic [3:0] n [4];
    for (int i = 0; i < 4; i++) begin
      n[i] = x[15 - 4*i -: 4];
      n[i] = iv ? INV[n[i]] : FWD[n[i]];
    end
    return {n[0], n[3], n[2], n[1]};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (n_rst && dn) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_dn: got dn=1 c=%h expected no pulse", c);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard_c", c, e);
      end
    end
  end

  // Drive ld for one sampling edge; returns at the negedge after the latch edge.
  task automatic start(logic [15:0] sv, logic iv, bit push);
    @(negedge clk);
    s   = sv;
    inv = iv;
    ld  = 1'b1;
    if (push) exp_q.push_back(model(sv, iv));
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_dn(bit noise, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (noise) begin
        s   = 16'($urandom);
        inv = 1'($urandom);
        ld  = 1'($urandom);
      end
      @(negedge clk);
      if (dn) begin
        lat = k;
        break;
      end
    end
    if (noise) ld = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL dn_timeout: got no dn within 20 cycles expected dn");
    end
  endtask

  task automatic op(logic [15:0] sv, logic iv, bit noise);
    int lat;
    start(sv, iv, 1'b1);
    check("busy_after_ld", 16'(busy), 16'd1);
    wait_dn(noise, lat);
    check("latency", 16'(lat), 16'd5);
    check("busy_at_dn", 16'(busy), 16'd0);
    @(negedge clk);
    check("dn_width", 16'(dn), 16'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] r;
    logic [15:0] f;

    #12;
    check("rst_c", c, 16'h0000);
    check("rst_dn", 16'(dn), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    op(16'h1234, 1'b0, 1'b0);
    check("fwd_1234", c, 16'h4DBA);
    op(16'h0000, 1'b0, 1'b0);
    check("fwd_0000", c, 16'h9999);
    op(16'hFFFF, 1'b0, 1'b0);
    check("fwd_ffff", c, 16'h7777);
    op(16'hA5C0, 1'b0, 1'b0);
    check("fwd_a5c0", c, 16'h09C1);
    op(16'h4DBA, 1'b1, 1'b0);
    check("inv_4dba", c, 16'h1234);

    // abort mid-operation; no result is expected
    start(16'h5678, 1'b0, 1'b0);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("abort_c", c, 16'h0000);
    check("abort_dn", 16'(dn), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (8) @(negedge clk);
    op(16'h1234, 1'b0, 1'b0);
    check("after_abort", c, 16'h4DBA);

    // latched inputs only; stray ld pulses during busy must not add a dn
    for (int i = 0; i < 20; i++) begin
      op(16'($urandom), 1'($urandom), 1'b1);
      repeat (3) @(negedge clk);
    end

    // back-to-back with ld held high
    @(negedge clk);
    s = 16'h1234; inv = 1'b0; ld = 1'b1;
    exp_q.push_back(model(16'h1234, 1'b0));
    @(negedge clk);
    s = 16'h0000;
    exp_q.push_back(model(16'h0000, 1'b0));
    wait_dn(1'b0, lat);
    check("b2b_first_lat", 16'(lat), 16'd5);
    check("b2b_first_c", c, 16'h4DBA);
    wait_dn(1'b0, lat);
    ld = 1'b0;
    check("b2b_spacing", 16'(lat), 16'd6);
    check("b2b_second_c", c, 16'h9999);
    repeat (4) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      r = {4'(v), 4'(v), 4'(v), 4'(v)};
      op(model(r, 1'b0), 1'b1, 1'b0);
      check("sweep_roundtrip", c, r);
    end

    for (int i = 0; i < 150; i++) begin
      r = 16'($urandom);
      op(r, 1'($urandom), 1'b0);
    end

    for (int i = 0; i < 100; i++) begin
      r = 16'($urandom);
      f = model(r, 1'b0);
      op(f, 1'b1, 1'b0);
      check("rand_roundtrip", c, r);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_shift.md
# sub_shift

Combined SubNibbles + ShiftRows stage of the 16-bit (nibble-based) AES datapath, sitting directly upstream of the mix-column stage. It substitutes the four state nibbles serially, one per clock, through a single shared S-box, then swaps the second-row nibbles. It presents the result on `c` with a one-cycle `dn` pulse, shaped to drive the mix-column stage's `c`/`ld` inputs directly. An `inv` input selects the inverse S-box for the decryption path.

## Interface
- No parameters; S-box contents and state encodings come from the shared package.
- clk  input  1  single system clock; all state changes on posedge
- n_rst  input  1  asynchronous, active-low reset
- ld  input  1  start request, sampled only in IDLE
- inv  input  1  0 = forward S-box, 1 = inverse S-box; latched with `ld`
- s  input  16  input state; column-major nibbles [15:12]=s00, [11:8]=s10, [7:4]=s01, [3:0]=s11
- c  output  16  substituted-and-shifted state; same nibble layout as `s`
- dn  output  1  one-cycle done pulse; `c` is valid when it asserts
- busy  output  1  high while a transform is in progress (SUB or SHIFT)

## Operation
- Forward S-box (0..F): 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7.
- Inverse S-box (0..F): A,5,9,B,1,7,8,F,6,0,2,3,C,4,D,E.
- ShiftRows: swap nibbles [11:8] and [3:0]. Nibbles [15:12] and [7:4] are unchanged.
- Because the swap is its own inverse and commutes with nibble-wise substitution, the same order (substitute, then swap) serves both modes.
- FSM states and transitions:
  - IDLE, ld=1: latch `s` into the working register, latch `inv`, clear the nibble index, go to SUB.
  - SUB: replace working nibble idx with S-box(nibble). idx 0 is [15:12], 1 is [11:8], 2 is [7:4], 3 is [3:0]. Increment idx each cycle. After idx=3, go to SHIFT.
  - SHIFT: write the swapped working register to `c`, set `dn`=1, go to IDLE.
- In IDLE, `dn` is cleared to 0 on the next edge.
- `ld` is ignored outside IDLE. Changes to `s` or `inv` after the latch edge have no effect.
- `c` holds its last result until the next SHIFT writes it. It is not cleared in IDLE.
- The 2-bit idx is sized exactly for four nibbles; it cannot overflow.

## Timing
- Reset values: `c`=16'h0000, `dn`=0, `busy`=0, state=IDLE, idx=0, working register=0.
- Reset mid-operation aborts immediately. No `dn` is produced, and the block is in IDLE after reset deasserts.
- Latency: if `ld` is sampled at edge N, SUB runs on edges N+1..N+4 and SHIFT on edge N+5. `c` and `dn`=1 are visible after edge N+5, and `dn` returns to 0 after edge N+6.
- `busy` is 1 after edges N..N+4 and 0 after edge N+5.
- Back-to-back operation: `ld` held high during the `dn` cycle is accepted at edge N+6. The second `dn` follows after edge N+11, giving 1 result per 6 cycles.
- If `ld` and `dn` are high in the same cycle, both take effect: the new operation starts and `dn` still falls after that edge.
- `dn` is exactly one cycle wide and never asserts without a preceding accepted `ld`.

## Structure
- Shared package (AES-wide): forward and inverse S-box constant arrays, the FSM state encodings (IDLE, SUB, SHIFT), and the nibble-index width.
- One natural sub-module: `nibble_sbox`, purely combinational, with 4-bit in, an `inv` select, and 4-bit out. It is instantiated once here, and the same sub-module is reused by key expansion.
- Top level contains the FSM, idx counter, working register, and output register only.

## Test plan
- Reset during operation: assert n_rst=0 two cycles after `ld` -> `c`=0000, `dn`=0, `busy`=0 immediately. Next `ld` with s=1234 -> `c`=4DBA, with normal latency.
- Forward: s=1234, inv=0, ld pulse -> `dn` after 5 edges with `c`=4DBA. s=0000 -> 9999; s=FFFF -> 7777; s=A5C0 -> 09C1.
- Inverse round-trip: s=4DBA, inv=1 -> `c`=1234. Sweep all 65536 forward results through inverse mode and require identity.
- Input stability: change `s` and toggle `inv` every cycle while busy, and pulse `ld` during SUB -> result reflects only the latched values, and exactly one `dn` is produced.
- Back-to-back: hold `ld`=1 continuously with s=1234, then 0000 -> `dn` pulses 6 cycles apart, with `c`=4DBA then 9999.
- Chain into the mix-column stage: connect `c`/`dn` to its `c`/`ld` -> the end-to-end result matches the software S-AES round model, excluding AddRoundKey, for 1000 random states.
